// File: rtl/eq_pkg.sv
// Shared types for the equation checker: FSM states, equation modes and the
// micro-op table that sequences the single ALU through CALC0..CALC3.
package eq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_X, S_WAIT_X, S_LOAD_Y, S_WAIT_Y, S_LOAD_Z, S_WAIT_Z,
        S_CALC0, S_CALC1, S_CALC2, S_CALC3, S_COMPARE, S_PASS, S_FAIL
    } state_e;

    typedef enum logic [1:0] {
        MODE_SQDIV  = 2'd0,  // (X/Z)^2 + Y/Z
        MODE_MULADD = 2'd1,  // X*Y + Z
        MODE_SUMDIV = 2'd2,  // (X+Y)/Z
        MODE_SQSUB  = 2'd3   // X*X - Y
    } mode_e;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} alu_op_e;
    typedef enum logic [2:0] {SEL_X, SEL_Y, SEL_Z, SEL_T, SEL_U} sel_e;
    typedef enum logic [1:0] {DST_NONE, DST_T, DST_U, DST_R} dst_e;

    typedef struct packed {
        alu_op_e op;
        sel_e    a;
        sel_e    b;
        dst_e    dst;
    } uop_t;

    // T and U are scratch registers; DST_R writes the visible Result.
    function automatic uop_t get_uop(input mode_e mode, input logic [1:0] step);
        uop_t u;
        u = '{OP_ADD, SEL_X, SEL_X, DST_NONE};
        case (mode)
            MODE_SQDIV: case (step)
                2'd0: u = '{OP_DIV, SEL_X, SEL_Z, DST_T};
                2'd1: u = '{OP_MUL, SEL_T, SEL_T, DST_T};
                2'd2: u = '{OP_DIV, SEL_Y, SEL_Z, DST_U};
                default: u = '{OP_ADD, SEL_T, SEL_U, DST_R};
            endcase
            MODE_MULADD: case (step)
                2'd0: u = '{OP_MUL, SEL_X, SEL_Y, DST_T};
                2'd1: u = '{OP_ADD, SEL_T, SEL_Z, DST_R};
                default: ;
            endcase
            MODE_SUMDIV: case (step)
                2'd0: u = '{OP_ADD, SEL_X, SEL_Y, DST_T};
                2'd1: u = '{OP_DIV, SEL_T, SEL_Z, DST_R};
                default: ;
            endcase
            default: case (step)
                2'd0: u = '{OP_MUL, SEL_X, SEL_X, DST_T};
                2'd1: u = '{OP_SUB, SEL_T, SEL_Y, DST_R};
                default: ;
            endcase
        endcase
        return u;
    endfunction

endpackage

// File: rtl/eq_alu.sv
// Combinational W-bit unsigned ALU; results wrap mod 2^W, divide-by-zero
// returns all-ones and raises div_zero.
module eq_alu
    import eq_pkg::*;
#(
    parameter int W = 8
) (
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y,
    output logic           div_zero
);

    always_comb begin
        y        = '0;
        div_zero = 1'b0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_MUL: y = a * b;
            OP_DIV: begin
                if (b == '0) begin
                    y        = '1;
                    div_zero = 1'b1;
                end else begin
                    y = a / b;
                end
            end
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/equation_checker.sv
// Operand-entry quiz FSM: collects X/Y/Z, evaluates the latched equation in a
// fixed four-cycle ALU sequence and scores it against the latched target.
module equation_checker
    import eq_pkg::*;
#(
    parameter  int W         = 8,
    parameter  int MAX_TRIES = 3,
    localparam int AW        = $clog2(MAX_TRIES + 1)
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic          Abort,
    input  logic          Go,
    input  logic [1:0]    Mode,
    input  logic [W-1:0]  Target,
    input  logic [W-1:0]  DataIn,
    output logic          Busy,
    output logic          Done,
    output logic          Correct,
    output logic          Fail,
    output logic          Retry,
    output logic          DivZero,
    output logic [AW-1:0] Attempts,
    output logic [W-1:0]  Result
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [W-1:0]  target_q, target_d, x_q, x_d, y_q, y_d, z_q, z_d;
    logic [W-1:0]  t_q, t_d, u_q, u_d, result_q, result_d;
    logic [AW-1:0] attempts_q, attempts_d;
    logic          div_zero_q, div_zero_d, done_q, done_d, retry_q, retry_d;

    logic [1:0]    calc_step;
    uop_t          uop;
    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic          alu_dz;

    always_comb begin
        case (state_q)
            S_CALC1: calc_step = 2'd1;
            S_CALC2: calc_step = 2'd2;
            S_CALC3: calc_step = 2'd3;
            default: calc_step = 2'd0;
        endcase
        uop = get_uop(mode_q, calc_step);
        case (uop.a)
            SEL_X:   alu_a = x_q;
            SEL_Y:   alu_a = y_q;
            SEL_Z:   alu_a = z_q;
            SEL_T:   alu_a = t_q;
            default: alu_a = u_q;
        endcase
        case (uop.b)
            SEL_X:   alu_b = x_q;
            SEL_Y:   alu_b = y_q;
            SEL_Z:   alu_b = z_q;
            SEL_T:   alu_b = t_q;
            default: alu_b = u_q;
        endcase
    end

    eq_alu #(.W(W)) u_alu (
        .op       (uop.op),
        .a        (alu_a),
        .b        (alu_b),
        .y        (alu_y),
        .div_zero (alu_dz)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        target_d   = target_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        t_d        = t_q;
        u_d        = u_q;
        result_d   = result_q;
        attempts_d = attempts_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        retry_d    = 1'b0;
        // Abort wins over everything, including a simultaneous Start.
        if (Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_PASS, S_FAIL: if (Start) begin
                    state_d    = S_LOAD_X;
                    mode_d     = mode_e'(Mode);
                    target_d   = Target;
                    attempts_d = '0;
                    div_zero_d = 1'b0;
                end
                S_LOAD_X: if (Go) begin x_d = DataIn; state_d = S_WAIT_X; end
                S_WAIT_X: if (!Go) state_d = S_LOAD_Y;
                S_LOAD_Y: if (Go) begin y_d = DataIn; state_d = S_WAIT_Y; end
                S_WAIT_Y: if (!Go) state_d = S_LOAD_Z;
                S_LOAD_Z: if (Go) begin z_d = DataIn; state_d = S_WAIT_Z; end
                S_WAIT_Z: if (!Go) state_d = S_CALC0;
                S_CALC0, S_CALC1, S_CALC2, S_CALC3: begin
                    case (uop.dst)
                        DST_T:   t_d      = alu_y;
                        DST_U:   u_d      = alu_y;
                        DST_R:   result_d = alu_y;
                        default: ;
                    endcase
                    if (alu_dz) div_zero_d = 1'b1;
                    state_d = (state_q == S_CALC3) ? S_COMPARE : state_e'(state_q + 4'd1);
                end
                S_COMPARE: begin
                    if (result_q == target_q && !div_zero_q) begin
                        state_d = S_PASS;
                        done_d  = 1'b1;
                    end else if (int'(attempts_q) + 1 < MAX_TRIES) begin
                        state_d    = S_LOAD_X;
                        attempts_d = attempts_q + 1'b1;
                        retry_d    = 1'b1;
                        div_zero_d = 1'b0;
                    end else begin
                        state_d    = S_FAIL;
                        attempts_d = AW'(MAX_TRIES);
                        done_d     = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_SQDIV;
            target_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            t_q        <= '0;
            u_q        <= '0;
            result_q   <= '0;
            attempts_q <= '0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            retry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            t_q        <= t_d;
            u_q        <= u_d;
            result_q   <= result_d;
            attempts_q <= attempts_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            retry_q    <= retry_d;
        end
    end

    assign Busy     = !(state_q inside {S_IDLE, S_PASS, S_FAIL});
    assign Done     = done_q;
    assign Correct  = (state_q == S_PASS);
    assign Fail     = (state_q == S_FAIL);
    assign Retry    = retry_q;
    assign DivZero  = div_zero_q;
    assign Attempts = attempts_q;
    assign Result   = result_q;

endmodule

// File: tb/tb_equation_checker.sv
// Directed bench: stimulus pushes expected Done/Retry events into a queue and
// a negedge monitor pops and compares them whenever the DUT raises one.
module tb_equation_checker;

    localparam int W  = 8;
    localparam int MT = 2;
    localparam int AW = $clog2(MT + 1);

    logic          Clock = 1'b0;
    logic          Resetn, Start, Abort, Go;
    logic [1:0]    Mode;
    logic [W-1:0]  Target, DataIn;
    logic          Busy, Done, Correct, Fail, Retry, DivZero;
    logic [AW-1:0] Attempts;
    logic [W-1:0]  Result;

    equation_checker #(.W(W), .MAX_TRIES(MT)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort), .Go(Go),
        .Mode(Mode), .Target(Target), .DataIn(DataIn), .Busy(Busy), .Done(Done),
        .Correct(Correct), .Fail(Fail), .Retry(Retry), .DivZero(DivZero),
        .Attempts(Attempts), .Result(Result)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]    kind;   // {Done, Retry}
        logic [W-1:0]  res;
        logic          cor;
        logic          fl;
        logic [AW-1:0] att;
        logic          dz;
        logic          busy;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [1:0] EV_DONE  = 2'b10;
    localparam logic [1:0] EV_RETRY = 2'b01;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic push(input logic [1:0] k, input logic [W-1:0] r, input logic c,
                        input logic f, input logic [AW-1:0] a, input logic d, input logic b);
        exp_t e;
        e = '{k, r, c, f, a, d, b};
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_round(input logic [1:0] m, input logic [W-1:0] tg);
        Mode = m; Target = tg; Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic enter(input logic [W-1:0] v);
        Go = 1'b1; DataIn = v;
        step();
        Go = 1'b0;
        step();
    endtask

    // Enters X/Y/Z; the scoring event must land exactly on the 5th edge after WAIT_Z exit.
    task automatic attempt(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] z, input logic dz);
        enter(x); enter(y); enter(z);
        repeat (4) step();
        chk("busy_in_compare", Busy, 1);
        chk("no_early_event", {Done, Retry}, 0);
        chk("divzero_at_compare", DivZero, dz);
        step();
        chk("event_on_5th_edge", Done | Retry, 1);
    endtask

    always @(negedge Clock) begin
        if (Resetn === 1'b1 && (Done || Retry)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {Done, Retry}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ev_kind", {Done, Retry}, e.kind);
                chk("ev_result", Result, e.res);
                chk("ev_correct", Correct, e.cor);
                chk("ev_fail", Fail, e.fl);
                chk("ev_attempts", Attempts, e.att);
                chk("ev_divzero", DivZero, e.dz);
                chk("ev_busy", Busy, e.busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Resetn = 1'b0; Start = 1'b0; Abort = 1'b0; Go = 1'b0;
        Mode = '0; Target = '0; DataIn = '0;
        step(); step();
        chk("reset_outputs", {Busy, Done, Correct, Fail, Retry, DivZero, Attempts, Result}, 0);
        Resetn = 1'b1;
        step();

        // Mode0: (12/3)^2 + 6/3 = 18
        push(EV_DONE, 8'd18, 1, 0, 0, 0, 0);
        start_round(2'd0, 8'd18);
        attempt(8'd12, 8'd6, 8'd3, 0);
        step();
        chk("done_is_pulse", Done, 0);
        chk("correct_holds", Correct, 1);

        // Mode1: 400 mod 256 + 5 = 149
        push(EV_DONE, 8'd149, 1, 0, 0, 0, 0);
        start_round(2'd1, 8'd149);
        attempt(8'd20, 8'd20, 8'd5, 0);

        // Mode2 with Z=0: all-ones result equals target but is still scored wrong
        push(EV_RETRY, 8'd255, 0, 0, 1, 0, 1);
        start_round(2'd2, 8'd255);
        attempt(8'd4, 8'd4, 8'd0, 1);
        push(EV_DONE, 8'd255, 1, 0, 1, 0, 0);
        attempt(8'd250, 8'd5, 8'd1, 0);

        // Mode3: 3*3-1 = 8 vs target 0, twice -> FAIL
        push(EV_RETRY, 8'd8, 0, 0, 1, 0, 1);
        start_round(2'd3, 8'd0);
        attempt(8'd3, 8'd1, 8'd0, 0);
        push(EV_DONE, 8'd8, 0, 1, 2, 0, 0);
        attempt(8'd3, 8'd1, 8'd0, 0);
        step();
        chk("fail_holds", Fail, 1);
        start_round(2'd1, 8'd17);
        chk("start_clears_attempts", Attempts, 0);
        chk("start_sets_busy", Busy, 1);

        // Go held in WAIT_Y with DataIn changing; only Y=7 is captured. 2*7+3 = 17
        enter(8'd2);
        Go = 1'b1; DataIn = 8'd7;
        step();
        for (int i = 0; i < 9; i++) begin
            DataIn = 8'(99 + i);
            step();
        end
        chk("busy_while_go_held", Busy, 1);
        Go = 1'b0;
        step();
        enter(8'd3);
        push(EV_DONE, 8'd17, 1, 0, 0, 0, 0);
        step();
        Start = 1'b1; Mode = 2'd3; Target = 8'd0;
        step();
        Start = 1'b0;
        step(); step();
        chk("start_in_calc_no_early_done", Done, 0);
        step();
        chk("done_after_ignored_start", Done, 1);

        // Reset mid-round in CALC2
        start_round(2'd0, 8'd18);
        enter(8'd12); enter(8'd6); enter(8'd3);
        step(); step();
        Resetn = 1'b0;
        step();
        chk("reset_mid_calc_outputs",
            {Busy, Done, Correct, Fail, Retry, DivZero, Attempts, Result}, 0);
        Resetn = 1'b1;
        step();
        chk("idle_after_reset", Busy, 0);

        // Abort in WAIT_X keeps Attempts/Result; Abort overrides Start
        push(EV_RETRY, 8'd8, 0, 0, 1, 0, 1);
        start_round(2'd3, 8'd0);
        attempt(8'd3, 8'd1, 8'd0, 0);
        Go = 1'b1; DataIn = 8'd9;
        step();
        Abort = 1'b1;
        step();
        chk("abort_busy", Busy, 0);
        chk("abort_attempts_kept", Attempts, 1);
        chk("abort_result_kept", Result, 8);
        chk("abort_flags", {Done, Retry, Correct, Fail}, 0);
        Start = 1'b1;
        step();
        chk("abort_overrides_start", Busy, 0);
        Abort = 1'b0; Start = 1'b0; Go = 1'b0;
        step(); step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
